// File: rtl/match_ctrl_multi.sv
// match_ctrl_multi: multi-channel match arbiter with saturating count, halt and resume.
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset
//   match_flag   - per-channel match requests, level-sampled
//   halt_flag    - external halt request, level
//   resume       - leave HALT (only looked at in HALT)
//   enable_count - high while in MATCH, decoded from the state register
//   ch_enable    - registered per-channel grant
//   match_count  - saturating total of granted channel-cycles
//   limit_hit    - sticky: HALT was entered because the limit was reached
//   state        - 0 IDLE, 1 MATCH, 2 HALT (3 illegal, recovers to IDLE)
module match_ctrl_multi #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 8,
    parameter int HALT_LIMIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  match_flag,
    input  logic             halt_flag,
    input  logic             resume,
    output logic             enable_count,
    output logic [N_CH-1:0]  ch_enable,
    output logic [CNT_W-1:0] match_count,
    output logic             limit_hit,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE = 2'd0, MATCH = 2'd1, HALT = 2'd2, ILL = 2'd3} state_t;
    localparam int SW = CNT_W + 5;
    // the state register is kept as plain bits so an illegal encoding can exist and recover
    logic [1:0]       state_q;
    state_t           state_d;
    logic [N_CH-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic             lh_q, lh_d, lim;
    logic [4:0]       pop;
    logic [SW-1:0]    sum;
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) pop = pop + 5'(ch_q[i]);
    end
    // widened sum so saturation is detected instead of wrapping
    assign sum    = {5'b0, cnt_q} + {{(SW-5){1'b0}}, pop};
    assign cnt_nx = (sum > {5'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    assign lim    = (HALT_LIMIT != 0) && (cnt_nx >= CNT_W'(HALT_LIMIT));
    always_comb begin
        state_d = state_t'(state_q);
        ch_d    = '0;
        cnt_d   = cnt_q;
        lh_d    = lh_q;
        case (state_q)
            IDLE: begin
                if (halt_flag) state_d = HALT;
                else if (|match_flag) begin
                    state_d = MATCH;
                    ch_d    = match_flag;
                end
            end
            MATCH: begin
                // the grants of the previous edge are counted on every MATCH edge, even when leaving
                cnt_d = cnt_nx;
                if (halt_flag) state_d = HALT;
                else if (lim) begin
                    state_d = HALT;
                    lh_d    = 1'b1;
                end
                else if (|match_flag) ch_d = match_flag;
                else state_d = IDLE;
            end
            HALT: begin
                if (resume && !halt_flag) begin
                    state_d = IDLE;
                    if (lh_q) begin
                        cnt_d = '0;
                        lh_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            lh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            lh_q    <= lh_d;
        end
    end
    assign enable_count = (state_q == MATCH);
    assign ch_enable    = ch_q;
    assign match_count  = cnt_q;
    assign limit_hit    = lh_q;
    assign state        = state_q;
endmodule

// File: tb/tb_match_ctrl_multi.sv
// tb_match_ctrl_multi: checks three configurations of match_ctrl_multi against a rule-level model.
module tb_match_ctrl_multi;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] match_flag = '0;
    logic       halt_flag = 1'b0;
    logic       resume = 1'b0;
    logic [1:0] o_st[3];
    logic       o_en[3];
    logic [3:0] o_ch[3];
    logic [7:0] o_cnt[3];
    logic       o_lh[3];
    logic [7:0] c0, c1;
    logic [2:0] c2;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  cmp_en = 1'b0;
    int  cw[3] = '{8, 8, 3};
    int  hl[3] = '{0, 10, 0};
    int  m_st[3];
    int  m_ch[3];
    int  m_cnt[3];
    int  m_lh[3];
    always #5 clk = ~clk;
    match_ctrl_multi #(.N_CH(4), .CNT_W(8), .HALT_LIMIT(0)) d0 (
        .clk(clk), .reset(reset), .match_flag(match_flag), .halt_flag(halt_flag), .resume(resume),
        .enable_count(o_en[0]), .ch_enable(o_ch[0]), .match_count(c0), .limit_hit(o_lh[0]), .state(o_st[0]));
    match_ctrl_multi #(.N_CH(4), .CNT_W(8), .HALT_LIMIT(10)) d1 (
        .clk(clk), .reset(reset), .match_flag(match_flag), .halt_flag(halt_flag), .resume(resume),
        .enable_count(o_en[1]), .ch_enable(o_ch[1]), .match_count(c1), .limit_hit(o_lh[1]), .state(o_st[1]));
    match_ctrl_multi #(.N_CH(4), .CNT_W(3), .HALT_LIMIT(0)) d2 (
        .clk(clk), .reset(reset), .match_flag(match_flag), .halt_flag(halt_flag), .resume(resume),
        .enable_count(o_en[2]), .ch_enable(o_ch[2]), .match_count(c2), .limit_hit(o_lh[2]), .state(o_st[2]));
    assign o_cnt[0] = c0;
    assign o_cnt[1] = c1;
    assign o_cnt[2] = {5'b0, c2};
    task automatic chk(input string n, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", n, a, e);
        end
    endtask
    // model: the controller's rules stated directly on integers
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int nc;
            if (reset) begin
                m_st[k] = 0; m_ch[k] = 0; m_cnt[k] = 0; m_lh[k] = 0;
            end else if (m_st[k] == 0) begin
                m_ch[k] = 0;
                if (halt_flag) m_st[k] = 2;
                else if (match_flag != 0) begin m_st[k] = 1; m_ch[k] = int'(match_flag); end
            end else if (m_st[k] == 1) begin
                nc = m_cnt[k] + $countones(m_ch[k]);
                if (nc > (1 << cw[k]) - 1) nc = (1 << cw[k]) - 1;
                m_cnt[k] = nc;
                m_ch[k] = 0;
                if (halt_flag) m_st[k] = 2;
                else if (hl[k] != 0 && nc >= hl[k]) begin m_st[k] = 2; m_lh[k] = 1; end
                else if (match_flag != 0) m_ch[k] = int'(match_flag);
                else m_st[k] = 0;
            end else if (m_st[k] == 2) begin
                m_ch[k] = 0;
                if (resume && !halt_flag) begin
                    m_st[k] = 0;
                    if (m_lh[k] != 0) begin m_cnt[k] = 0; m_lh[k] = 0; end
                end
            end else begin
                m_st[k] = 0; m_ch[k] = 0;
            end
        end
    end
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d.state", k), int'(o_st[k]), m_st[k]);
                chk($sformatf("d%0d.enable_count", k), int'(o_en[k]), int'(m_st[k] == 1));
                chk($sformatf("d%0d.ch_enable", k), int'(o_ch[k]), m_ch[k]);
                chk($sformatf("d%0d.match_count", k), int'(o_cnt[k]), m_cnt[k]);
                chk($sformatf("d%0d.limit_hit", k), int'(o_lh[k]), m_lh[k]);
            end
        end
    end
    task automatic step(input logic [3:0] mf, input logic hf, input logic rs, input logic rst);
        match_flag = mf;
        halt_flag  = hf;
        resume     = rs;
        reset      = rst;
        @(negedge clk);
    endtask
    initial begin
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 0, 0, 1);
            cmp_en = 1'b1;
            chk("rst.state", int'(o_st[0]), 0);
            chk("rst.ch", int'(o_ch[0]), 0);
            chk("rst.cnt", int'(o_cnt[0]), 0);
        end
        step(4'b1111, 0, 0, 0);
        chk("release.state", int'(o_st[0]), 1);
        step(4'b0000, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 0, 0, 0);
            chk("s2.state", int'(o_st[0]), 1);
            chk("s2.ch", int'(o_ch[0]), 3);
            chk("s2.en", int'(o_en[0]), 1);
        end
        chk("s2.cnt_mid", int'(o_cnt[0]), 4);
        step(4'b0000, 0, 0, 0);
        chk("s2.exit_state", int'(o_st[0]), 0);
        chk("s2.exit_cnt", int'(o_cnt[0]), 6);
        step(4'b0000, 0, 0, 1);
        step(4'b0101, 0, 0, 0);
        step(4'b0101, 1, 0, 0);
        chk("s3.state", int'(o_st[0]), 2);
        chk("s3.en", int'(o_en[0]), 0);
        chk("s3.ch", int'(o_ch[0]), 0);
        chk("s3.cnt", int'(o_cnt[0]), 2);
        for (int i = 0; i < 2; i++) begin
            step(4'b1111, 0, 0, 0);
            chk("s3.hold_state", int'(o_st[0]), 2);
            chk("s3.hold_cnt", int'(o_cnt[0]), 2);
            chk("s3.hold_lh", int'(o_lh[0]), 0);
        end
        step(4'b0000, 0, 1, 0);
        chk("s3.resume_state", int'(o_st[0]), 0);
        chk("s3.resume_cnt", int'(o_cnt[0]), 2);
        step(4'b0000, 0, 0, 1);
        step(4'b1111, 0, 0, 0);
        step(4'b1111, 0, 0, 0);
        chk("s4.cnt4", int'(o_cnt[1]), 4);
        chk("s5.cnt4", int'(o_cnt[2]), 4);
        step(4'b1111, 0, 0, 0);
        chk("s4.cnt8", int'(o_cnt[1]), 8);
        chk("s5.sat7", int'(o_cnt[2]), 7);
        step(4'b1111, 0, 0, 0);
        chk("s4.cnt12", int'(o_cnt[1]), 12);
        chk("s4.halt", int'(o_st[1]), 2);
        chk("s4.lh", int'(o_lh[1]), 1);
        chk("s5.hold7", int'(o_cnt[2]), 7);
        chk("s5.state", int'(o_st[2]), 1);
        step(4'b0000, 1, 1, 0);
        chk("s4.resume_blocked", int'(o_st[1]), 2);
        step(4'b0000, 0, 1, 0);
        chk("s4.resume_state", int'(o_st[1]), 0);
        chk("s4.resume_cnt", int'(o_cnt[1]), 0);
        chk("s4.resume_lh", int'(o_lh[1]), 0);
        chk("s4.d0_cnt16", int'(o_cnt[0]), 16);
        step(4'b0000, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(4'b1111, 0, 0, 0);
        chk("s6.pre_lh", int'(o_lh[1]), 1);
        step(4'b1111, 0, 0, 1);
        chk("s6.state", int'(o_st[1]), 0);
        chk("s6.ch", int'(o_ch[1]), 0);
        chk("s6.cnt", int'(o_cnt[1]), 0);
        chk("s6.lh", int'(o_lh[1]), 0);
        chk("s6.en", int'(o_en[1]), 0);
        step(4'b0011, 0, 0, 0);
        step(4'b0000, 0, 0, 0);
        chk("s6.idle_cnt", int'(o_cnt[0]), 2);
        #2;
        force d0.state_q = 2'd3;
        m_st[0] = 3;
        #1;
        chk("ill.state", int'(o_st[0]), 3);
        chk("ill.en", int'(o_en[0]), 0);
        #1;
        release d0.state_q;
        step(4'b0000, 0, 0, 0);
        chk("ill.recover_state", int'(o_st[0]), 0);
        chk("ill.recover_ch", int'(o_ch[0]), 0);
        chk("ill.recover_cnt", int'(o_cnt[0]), 2);
        step(4'b0000, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(4'b1111, 0, 0, 0);
        step(4'b1111, 1, 0, 0);
        chk("both.state", int'(o_st[1]), 2);
        chk("both.lh", int'(o_lh[1]), 0);
        chk("both.cnt", int'(o_cnt[1]), 12);
        step(4'b0000, 0, 1, 0);
        chk("both.resume_cnt", int'(o_cnt[1]), 12);
        step(4'b0000, 1, 0, 0);
        chk("idle_halt.state", int'(o_st[0]), 2);
        step(4'b0000, 0, 1, 0);
        chk("idle_halt.resume", int'(o_st[0]), 0);
        step(4'b0000, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
